// File: rtl/cpu_bus_frontend_pkg.sv
// cpu_bus_frontend shared types and defaults.
// Wait FSM state encoding and parameter defaults.
package cpu_bus_frontend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RELEASE
  } wait_state_t;

  localparam int SYNC_STAGES_DEF  = 2;
  localparam int WAIT_TIMEOUT_DEF = 63;

endpackage

// File: rtl/cpu_bus_frontend_if.sv
// Z80 pin-side bus bundle.
// master = CPU side, slave = frontend.
interface cpu_bus_frontend_if;
  logic        n_m1;
  logic        n_mreq;
  logic        n_iorq;
  logic        n_rd;
  logic        n_wr;
  logic        n_rfsh;
  logic [15:0] a_pin;
  logic [7:0]  d_pin;
  logic        n_wait;

  modport master (
    output n_m1, n_mreq, n_iorq,
    output n_rd, n_wr, n_rfsh,
    output a_pin, d_pin,
    input  n_wait
  );

  modport slave (
    input  n_m1, n_mreq, n_iorq,
    input  n_rd, n_wr, n_rfsh,
    input  a_pin, d_pin,
    output n_wait
  );
endinterface

// File: rtl/cpu_bus_frontend_sync.sv
// bus_sync_bit: per-bit synchroniser with optional glitch filter.
// Macro BUS_GLITCH_FILTER_EN adds a 2-sample agreement filter stage.
module bus_sync_bit #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk28,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sr;

  // shift chain, sr[0] is the first capture stage
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) sr <= {SYNC_STAGES{RESET_VAL}};
    else        sr <= {sr[SYNC_STAGES-2:0], din};
  end

`ifdef BUS_GLITCH_FILTER_EN
  logic filt;

  // follow the chain only when the last two samples agree
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) filt <= RESET_VAL;
    else if (sr[SYNC_STAGES-1] == sr[SYNC_STAGES-2])
      filt <= sr[SYNC_STAGES-1];
  end

  assign dout = filt;
`else
  assign dout = sr[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/cpu_bus_frontend.sv
// cpu_bus_frontend: Z80 pin synchroniser, edge pulses and /WAIT FSM.
// Optional macro BUS_GLITCH_FILTER_EN filters control strobes.
module cpu_bus_frontend
  import cpu_bus_frontend_pkg::*;
#(
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
  input  logic              rst_n,
  input  logic              clk28,
  input  logic              ck7,
  cpu_bus_frontend_if.slave bus,
  input  logic              ext_wait_cycle2,
  output logic              m1,
  output logic              mreq,
  output logic              ioreq,
  output logic              rd,
  output logic              wr,
  output logic              rfsh,
  output logic              mreq_fall,
  output logic              mreq_rise,
  output logic              ioreq_fall,
  output logic              ioreq_rise,
  output logic [15:0]       a,
  output logic [7:0]        d,
  output logic              wait_timeout
);

  logic [5:0] pin_act;
  logic [5:0] sync;
  logic       iorq_s;
  logic       mreq_d;
  logic       ioreq_d;
  logic [7:0] cnt;
  logic       cnt_last;
  logic       n_wait;

  wait_state_t state, state_nx;

  assign pin_act = {~bus.n_m1, ~bus.n_mreq, ~bus.n_iorq,
                    ~bus.n_rd, ~bus.n_wr,   ~bus.n_rfsh};

  for (genvar i = 0; i < 6; i++) begin : g_sync
    bus_sync_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (1'b0)
    ) u_sync (
      .clk28 (clk28),
      .rst_n (rst_n),
      .din   (pin_act[i]),
      .dout  (sync[i])
    );
  end

  assign m1     = sync[5];
  assign mreq   = sync[4];
  assign iorq_s = sync[3];
  assign rd     = sync[2];
  assign wr     = sync[1];
  assign rfsh   = sync[0];

  // interrupt acknowledge (M1+IORQ) is not an I/O cycle
  assign ioreq = iorq_s & ~m1;

  // one-cycle-delayed copies for edge detection
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      mreq_d  <= 1'b0;
      ioreq_d <= 1'b0;
    end else begin
      mreq_d  <= mreq;
      ioreq_d <= ioreq;
    end
  end

  assign mreq_fall  =  mreq  & ~mreq_d;
  assign mreq_rise  = ~mreq  &  mreq_d;
  assign ioreq_fall =  ioreq & ~ioreq_d;
  assign ioreq_rise = ~ioreq &  ioreq_d;

  // address/data re-sampled every cycle, qualified later by strobes
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      a <= 16'h0000;
      d <= 8'hFF;
    end else begin
      a <= bus.a_pin;
      d <= bus.d_pin;
    end
  end

  assign cnt_last = (cnt == 8'd1);

  // wait state, timeout counter and sticky timeout flag
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      wait_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == HOLD)
        cnt <= 8'(WAIT_TIMEOUT);
      else if (state == HOLD)
        cnt <= cnt - 8'd1;
      if (state == HOLD && !ioreq_rise &&
          ext_wait_cycle2 && cnt_last)
        wait_timeout <= 1'b1;
    end
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (ioreq_fall && ext_wait_cycle2)
          state_nx = HOLD;
      HOLD:
        if (ioreq_rise)
          state_nx = IDLE;
        else if (!ext_wait_cycle2 || cnt_last)
          state_nx = RELEASE;
      RELEASE:
        if (ioreq_rise || ck7)
          state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // /WAIT: released on the ck7 phase or at once on abort
  always_comb begin
    n_wait = 1'b1;
    unique case (state)
      HOLD:    n_wait = ioreq_rise;
      RELEASE: n_wait = ioreq_rise | ck7;
      default: n_wait = 1'b1;
    endcase
  end

  assign bus.n_wait = n_wait;

endmodule
